// File: rtl/main_bus_arbiter.sv
// Round-robin owner arbiter for the shared main memory bus.
// It holds the grant until the owner is idle, then inserts a turnaround gap. A hold watchdog revokes a stuck owner.
module main_bus_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = $clog2(NUM_REQ),
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] abtr_reqcyc,
  input  logic [NUM_REQ-1:0] bus_busy,
  output logic [NUM_REQ-1:0] abtr_grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout_err
);

  localparam int unsigned HOLD_W    = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned TURN_W    = 4;
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST_V = HOLD_W'(HOLD_LAST);
  localparam logic [TURN_W-1:0] TURN_INIT   = TURN_W'(TURNAROUND - 1);
  localparam logic [ID_W-1:0]   LAST_ID     = ID_W'(NUM_REQ - 1);
  localparam bit                WD_ENABLE   = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_TURN
  } state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                valid_q;
  logic [ID_W-1:0]     id_q;
  logic                timeout_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [TURN_W-1:0]   turn_cnt_q;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  int                  scan;
  logic                owner_active;
  logic                wd_hit;
  logic [ID_W-1:0]     next_ptr;

  // First requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan       = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      scan = int'(rr_ptr_q) + i;
      if (scan >= int'(NUM_REQ)) begin
        scan = scan - int'(NUM_REQ);
      end
      if (!pick_valid && abtr_reqcyc[ID_W'(scan)]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(scan);
      end
    end
  end

  assign owner_active = abtr_reqcyc[id_q] | bus_busy[id_q];
  assign wd_hit       = WD_ENABLE && (hold_cnt_q == HOLD_LAST_V);
  assign next_ptr     = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      timeout_q  <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q    <= NUM_REQ'(1) << pick_id;
            valid_q    <= 1'b1;
            id_q       <= pick_id;
            hold_cnt_q <= '0;
            state_q    <= ST_OWN;
          end
        end
        ST_OWN: begin
          // A normal release takes priority, so timeout_err only fires when the owner is still active.
          if (!owner_active || wd_hit) begin
            grant_q    <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            rr_ptr_q   <= next_ptr;
            turn_cnt_q <= TURN_INIT;
            timeout_q  <= owner_active;
            state_q    <= ST_TURN;
          end else if (hold_cnt_q != HOLD_SAT) begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_TURN: begin
          if (turn_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            turn_cnt_q <= turn_cnt_q - TURN_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign abtr_grant  = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed bench for main_bus_arbiter: one main instance and one with a short watchdog.
module tb_main_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] busy;
  logic [3:0] grant;
  logic       gvalid;
  logic [1:0] gid;
  logic       tout;

  logic [3:0] wd_req;
  logic [3:0] wd_busy;
  logic [3:0] wd_grant;
  logic       wd_gvalid;
  logic [1:0] wd_gid;
  logic       wd_tout;

  int n_checks;
  int n_fail;

  main_bus_arbiter #(.NUM_REQ(4), .ID_W(2), .TURNAROUND(1), .MAX_HOLD(1024)) dut (
    .clk(clk), .reset(reset), .abtr_reqcyc(req), .bus_busy(busy),
    .abtr_grant(grant), .grant_valid(gvalid), .grant_id(gid), .timeout_err(tout)
  );

  main_bus_arbiter #(.NUM_REQ(4), .ID_W(2), .TURNAROUND(1), .MAX_HOLD(8)) dut_wd (
    .clk(clk), .reset(reset), .abtr_reqcyc(wd_req), .bus_busy(wd_busy),
    .abtr_grant(wd_grant), .grant_valid(wd_gvalid), .grant_id(wd_gid), .timeout_err(wd_tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; busy = 4'b0000;
    wd_req = 4'b0000; wd_busy = 4'b0000;
    tick(); tick(); tick();
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_checks++; if (gvalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", gvalid); end
    n_checks++; if (gid !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", gid); end
    n_checks++; if (tout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", tout); end
    reset = 1'b1;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL first_grant got=%b exp=0001", grant); end
    n_checks++; if (gid !== 2'd0) begin n_fail++; $display("FAIL first_id got=%0d exp=0", gid); end
    n_checks++; if (gvalid !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%b exp=1", gvalid); end
  endtask

  task automatic test_round_robin();
    int exp_id;
    int gap;
    logic [3:0] exp_g;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      exp_g  = 4'(1) << exp_id;
      gap    = 0;
      while (!gvalid && gap < 10) begin tick(); gap++; end
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
      n_checks++; if (gid !== 2'(exp_id)) begin n_fail++; $display("FAIL rr_id k=%0d got=%0d exp=%0d", k, gid, exp_id); end
      n_checks++; if (gap != ((k == 0) ? 0 : 2)) begin n_fail++; $display("FAIL rr_gap k=%0d got=%0d exp=%0d", k, gap, (k == 0) ? 0 : 2); end
      for (int c = 1; c < 4; c++) begin
        tick();
        n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_hold k=%0d c=%0d got=%b exp=%b", k, c, grant, exp_g); end
      end
      req[exp_id] = 1'b0;
      tick();
      n_checks++; if (gvalid !== 1'b0) begin n_fail++; $display("FAIL rr_release k=%0d got=%b exp=0", k, gvalid); end
      if (k < 4) req[exp_id] = 1'b1;
      else req = 4'b0100;
    end
  endtask

  task automatic test_busy_hold();
    int gap;
    gap = 0;
    while (!gvalid && gap < 10) begin tick(); gap++; end
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL busy_grant got=%b exp=0100", grant); end
    req = 4'b0000; busy = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL busy_held c=%0d got=%b exp=0100", c, grant); end
    end
    busy = 4'b0000;
    tick();
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL busy_release got=%b exp=0000", grant); end
    n_checks++; if (tout !== 1'b0) begin n_fail++; $display("FAIL busy_no_timeout got=%b exp=0", tout); end
  endtask

  task automatic test_wrap();
    int gap;
    req = 4'b1000;
    gap = 0;
    while (!gvalid && gap < 10) begin tick(); gap++; end
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_owner3 got=%b exp=1000", grant); end
    n_checks++; if (gid !== 2'd3) begin n_fail++; $display("FAIL wrap_id3 got=%0d exp=3", gid); end
    req = 4'b1011;
    tick();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_ignore_others got=%b exp=1000", grant); end
    req = 4'b0011;
    tick();
    n_checks++; if (gvalid !== 1'b0) begin n_fail++; $display("FAIL wrap_release got=%b exp=0", gvalid); end
    gap = 0;
    while (!gvalid && gap < 10) begin tick(); gap++; end
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wrap_next got=%b exp=0001", grant); end
  endtask

  task automatic test_back_to_back();
    int gap;
    req = 4'b0010;
    tick();
    n_checks++; if (gvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_one_cycle got=%b exp=0", gvalid); end
    req = 4'b0011;
    gap = 0;
    while (!gvalid && gap < 10) begin tick(); gap++; end
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL b2b_reraise_low_prio got=%b exp=0010", grant); end
    n_checks++; if (gap != 2) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=2", gap); end
  endtask

  task automatic test_watchdog();
    int cnt;
    int gap;
    wd_req = 4'b0110;
    tick();
    n_checks++; if (wd_grant !== 4'b0010) begin n_fail++; $display("FAIL wd_grant1 got=%b exp=0010", wd_grant); end
    cnt = 0;
    while (wd_grant === 4'b0010 && cnt < 20) begin
      n_checks++; if (wd_tout !== 1'b0) begin n_fail++; $display("FAIL wd_early_timeout cnt=%0d got=%b exp=0", cnt, wd_tout); end
      cnt++;
      tick();
    end
    n_checks++; if (cnt != 8) begin n_fail++; $display("FAIL wd_hold_cycles got=%0d exp=8", cnt); end
    n_checks++; if (wd_tout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout_pulse got=%b exp=1", wd_tout); end
    n_checks++; if (wd_gvalid !== 1'b0) begin n_fail++; $display("FAIL wd_revoked got=%b exp=0", wd_gvalid); end
    tick();
    n_checks++; if (wd_tout !== 1'b0) begin n_fail++; $display("FAIL wd_pulse_width got=%b exp=0", wd_tout); end
    gap = 0;
    while (!wd_gvalid && gap < 10) begin tick(); gap++; end
    n_checks++; if (wd_grant !== 4'b0100) begin n_fail++; $display("FAIL wd_next_owner got=%b exp=0100", wd_grant); end
    n_checks++; if (wd_gid !== 2'd2) begin n_fail++; $display("FAIL wd_next_id got=%0d exp=2", wd_gid); end
    wd_req = 4'b0000;
  endtask

  task automatic test_reset_mid_own();
    busy = 4'b0010; req = 4'b0000;
    tick();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rst_busy_held got=%b exp=0010", grant); end
    reset = 1'b0; req = 4'b0011;
    tick();
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_drop_grant got=%b exp=0000", grant); end
    n_checks++; if (gid !== 2'd0) begin n_fail++; $display("FAIL rst_drop_id got=%0d exp=0", gid); end
    n_checks++; if (gvalid !== 1'b0) begin n_fail++; $display("FAIL rst_drop_valid got=%b exp=0", gvalid); end
    reset = 1'b1; busy = 4'b0000;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rst_restart_ptr got=%b exp=0001", grant); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_round_robin();
    test_busy_hold();
    test_wrap();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_own();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
